// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared state encoding, BCD helpers and seven-segment table
package whack_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Two-digit BCD increment that sticks at 99
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_mux.sv
// rtl/seg7_mux.sv - refresh counter, digit select and segment decode for a 4-digit display
module seg7_mux
    import whack_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [BCD_W-1:0] digit0,
    input  logic [BCD_W-1:0] digit1,
    input  logic [BCD_W-1:0] digit2,
    input  logic [BCD_W-1:0] digit3,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    logic [REFRESH_BITS-1:0] cnt_q;
    logic [REFRESH_BITS-1:0] cnt_d;
    logic [1:0]              sel;
    logic [BCD_W-1:0]        nib;

    assign cnt_d = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    assign sel   = cnt_q[REFRESH_BITS-1 -: 2];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        nib = digit0;
        case (sel)
            2'd0: nib = digit0;
            2'd1: nib = digit1;
            2'd2: nib = digit2;
            2'd3: nib = digit3;
            default: nib = digit0;
        endcase
    end

    assign an  = ~(4'b0001 << sel);
    assign seg = seg_decode(nib);

endmodule

// File: rtl/whack_score_keeper.sv
// rtl/whack_score_keeper.sv - game round FSM, BCD score/timer/high-score and display drive
module whack_score_keeper
    import whack_pkg::*;
#(
    parameter int ROUND_SECS   = 30,
    parameter int REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       start,
    input  logic       hit_pulse,
    input  logic       sec_tick,
    output logic       game_active,
    output logic       game_over,
    output logic [7:0] score_bcd,
    output logic [7:0] time_bcd,
    output logic [7:0] high_bcd,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [7:0] TIME_RELOAD = {4'(ROUND_SECS / 10), 4'(ROUND_SECS % 10)};

    logic [1:0] state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] time_q,  time_d;
    logic [7:0] high_q,  high_d;
    logic [7:0] shown_score;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            score_q <= 8'h00;
            time_q  <= TIME_RELOAD;
            high_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            time_q  <= time_d;
            high_q  <= high_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        time_d  = time_q;
        high_d  = high_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                // A hit coinciding with start is dropped: the round begins at 00
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = 8'h00;
                    time_d  = TIME_RELOAD;
                end
            end
            ST_PLAY: begin
                if (hit_pulse) begin
                    score_d = bcd_inc_sat(score_q);
                end
                if (sec_tick) begin
                    time_d = bcd_dec(time_q);
                    // Final tick: compare against score_d so a same-cycle hit counts
                    if (time_q == 8'h01) begin
                        state_d = ST_OVER;
                        if (score_d > high_q) begin
                            high_d = score_d;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign game_active = (state_q == ST_PLAY);
    assign game_over   = (state_q == ST_OVER);
    assign score_bcd   = score_q;
    assign time_bcd    = time_q;
    assign high_bcd    = high_q;

    assign shown_score = (state_q == ST_IDLE) ? high_q : score_q;

    seg7_mux #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_seg7_mux (
        .clk    (clk),
        .clear_n(clear_n),
        .digit0 (shown_score[3:0]),
        .digit1 (shown_score[7:4]),
        .digit2 (time_q[3:0]),
        .digit3 (time_q[7:4]),
        .seg    (seg),
        .an     (an)
    );

endmodule

// File: doc/whack_score_keeper.md
Name: whack_score_keeper

Overview:
- Consumer end of the whack-a-mole hit path. The mole/button front end emits one-`clk`-wide hit strobes on its `count_pulse` line; this block receives them.
- Runs the game round state machine with a BCD countdown timer.
- Accumulates the BCD score and keeps a high score.
- Drives a multiplexed 4-digit seven-segment display: time left on the left pair, score on the right pair.

Parameters:
- ROUND_SECS, 30: round length in seconds; legal range 1..99, loaded as 2-digit BCD.
- REFRESH_BITS, 16: width of the display refresh counter; its top 2 bits select the active digit.

Ports:
- clk  in  1  system clock, the same fast clock the pulse generators use.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start strobe, already synchronised.
- hit_pulse  in  1  hit strobe; each cycle it is high counts as one hit.
- sec_tick  in  1  one-cycle strobe, once per second.
- game_active  out  1  high while in PLAY.
- game_over  out  1  high while in OVER.
- score_bcd  out  8  current score, {tens, ones} BCD.
- time_bcd  out  8  seconds remaining, {tens, ones} BCD.
- high_bcd  out  8  best score since reset, BCD.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[3] is the leftmost digit.

Behaviour:
- Reset (clear_n low, async):
  - state=IDLE; score_bcd=8'h00; high_bcd=8'h00.
  - time_bcd=BCD(ROUND_SECS); refresh counter=0.
  - game_active=0, game_over=0, an=4'b1110, seg=pattern of the digit selected at reset.
  - Release is synchronous to clk; the first active edge after release sees the IDLE state.
- States: IDLE, PLAY, OVER. All outputs are registered or decoded from registers.
- IDLE: start=1 -> PLAY at the next edge; the same edge sets score=00 and time=BCD(ROUND_SECS).
- PLAY:
  - hit_pulse=1 -> score +1 in BCD at the next edge (09->10, 19->20); saturates at 99.
  - sec_tick=1 -> time -1 in BCD at the next edge (10->09).
  - When time=01 and sec_tick=1: time becomes 00 and state becomes OVER on the same edge.
  - A hit_pulse in that same cycle still counts.
  - start in PLAY is ignored.
- OVER:
  - On the edge entering OVER, high_bcd is loaded with the final score if it is strictly greater than high_bcd. The comparison includes a hit counted on that same edge.
  - hit_pulse and sec_tick are ignored.
  - start=1 -> PLAY with score=00 and time reloaded; high_bcd is retained.
- hit_pulse and sec_tick in IDLE or OVER have no effect. Score and time hold their values.
- Simultaneous start and hit in IDLE/OVER: the new round starts at 00; that hit is not counted.
- high_bcd is cleared only by reset.
- Display:
  - The refresh counter increments every clk and wraps freely.
  - The digit select is counter[REFRESH_BITS-1:REFRESH_BITS-2]: sel=0 -> an[0] score ones, 1 -> an[1] score tens, 2 -> an[2] time ones, 3 -> an[3] time tens. Exactly one an bit is low.
  - In IDLE the score digits show high_bcd instead of score_bcd.
  - No leading-zero blanking.
  - A non-BCD nibble (not reachable in normal operation) shows segment g only: seg=7'b0111111.
- seg and an are combinational from registered state; there is no added latency.

Decomposition:
- Shared package whack_pkg holds:
  - state encoding: IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
  - BCD nibble width.
  - seven-segment constant table for 0-9 plus the dash pattern.
- One sub-module, seg7_mux: refresh counter, digit select, nibble-to-segment decode. It takes four nibbles and outputs seg/an.
- The FSM and the BCD score/time/high registers stay in the top module.

Test Plan:
- Reset mid-PLAY with score=37, time=12 -> outputs return to IDLE values immediately and asynchronously: score 00, time 30, high 00, game_active=0.
- start, then 12 hit_pulses (some back-to-back) -> score_bcd=8'h12; hit pulses held high 3 cycles add 3.
- 105 hits in PLAY -> score_bcd saturates at 8'h99; after the round ends, high_bcd=8'h99.
- ROUND_SECS=30: 30 sec_ticks -> time passes 8'h10 -> 8'h09 correctly; on the 30th tick time=00, game_over=1, game_active=0. A hit in the same cycle as that tick is counted.
- Round 1 score 15, round 2 score 09 -> high stays 8'h15. Round 3 score 16 -> high becomes 8'h16. Hits and ticks in OVER leave all values unchanged.
- REFRESH_BITS=4: an cycles 1110, 1101, 1011, 0111 every 4 clks. With score 47 / time 23, seg shows 7, 4, 3, 2 in that order, each with the active-low patterns from whack_pkg.
